bullet_pool_ctrl: RTL

- Shared projectile controller for both tanks. It owns a fixed pool of bullet slots and round-robin arbitrates fire requests from tank 0 and tank 1, allowing one spawn per frame.
- Once per frame it advances every live bullet and retires any bullet that reaches the screen edge.
- It answers per-pixel "is bullet" queries for the colour mapper, replacing the per-tank bullet logic.

---
 rtl/bullet_pool_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/bullet_pool_ctrl.sv
`default_nettype none
// bullet_pool_ctrl: a pool of bullet slots shared by two tanks. Each frame it moves and retires bullets,
// then spawns at most one new bullet (round-robin between the tanks), and answers pixel hit queries. Rev 1.0
module bullet_pool_ctrl #(
  parameter int unsigned SLOTS  = 4,
  parameter logic [9:0]  STEP   = 10'd2,
  parameter logic [9:0]  X_MAX  = 10'd639,
  parameter logic [9:0]  Y_MAX  = 10'd479,
  parameter logic [9:0]  B_SIZE = 10'd8,
  parameter logic [9:0]  MUZZLE = 10'd12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic [1:0]       fire_req,
  input  logic [9:0]       tank0_X,
  input  logic [9:0]       tank0_Y,
  input  logic [9:0]       tank1_X,
  input  logic [9:0]       tank1_Y,
  input  logic [2:0]       tank0_dir,
  input  logic [2:0]       tank1_dir,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  output logic [1:0]       fire_gnt,
  output logic [SLOTS-1:0] slot_valid,
  output logic             is_bullet,
  output logic             bullet_owner,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned   IW       = $clog2(SLOTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(SLOTS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [9:0]    X_LIM    = X_MAX + 10'd1 - B_SIZE;
  localparam logic [9:0]    Y_LIM    = Y_MAX + 10'd1 - B_SIZE;
  localparam logic [9:0]    B_LAST   = B_SIZE - 10'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_SPAWN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2:0]       sync_q;
  logic [1:0]       pend_q, pend_d;
  logic             rr_q, rr_d;
  logic             overrun_q, overrun_d;
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [SLOTS-1:0] owner_q, owner_d;
  logic [2:0]       dir_q [SLOTS];
  logic [2:0]       dir_d [SLOTS];
  logic [9:0]       x_q   [SLOTS];
  logic [9:0]       x_d   [SLOTS];
  logic [9:0]       y_q   [SLOTS];
  logic [9:0]       y_d   [SLOTS];

  logic             frame_edge;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             cand;
  logic [2:0]       cand_dir;
  logic [9:0]       cand_x, cand_y;
  logic             dir_ok;
  logic [1:0]       gnt, pend_clr;
  logic [9:0]       cur_x, cur_y, x_inc, y_inc;
  logic [2:0]       cur_dir;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] holds the previous synchronised level
  assign frame_edge = sync_q[1] & ~sync_q[2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign cand     = (pend_q == 2'b11) ? rr_q : pend_q[1];
  assign cand_dir = cand ? tank1_dir : tank0_dir;
  assign cand_x   = (cand ? tank1_X : tank0_X) + MUZZLE;
  assign cand_y   = (cand ? tank1_Y : tank0_Y) + MUZZLE;
  assign dir_ok   = (cand_dir >= 3'd1) && (cand_dir <= 3'd4);

  assign cur_x    = x_q[idx_q];
  assign cur_y    = y_q[idx_q];
  assign cur_dir  = dir_q[idx_q];
  assign x_inc    = cur_x + STEP;
  assign y_inc    = cur_y + STEP;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    overrun_d = overrun_q | (frame_edge && (state_q != ST_IDLE));
    valid_d   = valid_q;
    owner_d   = owner_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    gnt       = 2'b00;
    pend_clr  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (frame_edge) begin
          state_d = ST_MOVE;
          idx_d   = '0;
        end
      end

      ST_MOVE: begin
        if (valid_q[idx_q]) begin
          case (cur_dir)
            3'd1: if (cur_y < STEP)  valid_d[idx_q] = 1'b0; else y_d[idx_q] = cur_y - STEP;
            3'd2: if (x_inc > X_LIM) valid_d[idx_q] = 1'b0; else x_d[idx_q] = x_inc;
            3'd3: if (cur_x < STEP)  valid_d[idx_q] = 1'b0; else x_d[idx_q] = cur_x - STEP;
            3'd4: if (y_inc > Y_LIM) valid_d[idx_q] = 1'b0; else y_d[idx_q] = y_inc;
            default: ;
          endcase
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_SPAWN;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      ST_SPAWN: begin
        state_d = ST_IDLE;
        // a full pool leaves every pending request untouched for the next frame
        if ((pend_q != 2'b00) && free_found) begin
          pend_clr[cand] = 1'b1;
          if (dir_ok) begin
            valid_d[free_idx] = 1'b1;
            owner_d[free_idx] = cand;
            dir_d[free_idx]   = cand_dir;
            x_d[free_idx]     = cand_x;
            y_d[free_idx]     = cand_y;
            gnt[cand]         = 1'b1;
            rr_d              = ~cand;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    pend_d = (pend_q & ~pend_clr) | fire_req;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pend_q    <= '0;
      rr_q      <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= '0;
      owner_q   <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        dir_q[i] <= '0;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      owner_q   <= owner_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // descending scan so the lowest-index hit supplies the owner
  always_comb begin
    is_bullet    = 1'b0;
    bullet_owner = 1'b0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (valid_q[i] &&
          (DrawX >= x_q[i]) && (DrawX <= x_q[i] + B_LAST) &&
          (DrawY >= y_q[i]) && (DrawY <= y_q[i] + B_LAST)) begin
        is_bullet    = 1'b1;
        bullet_owner = owner_q[i];
      end
    end
  end

  assign fire_gnt   = gnt;
  assign slot_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;

endmodule
`default_nettype wire
